// File: rtl/window_ctrl_if.sv
`timescale 1ns/1ps
// Pixel-in / window-out bundle for window_ctrl.
// DIN* is valid-only: a pixel is taken on every posedge where DIN_VALID is
// high (there is no ready), and WIN_* qualify the D* window the same way.
interface window_ctrl_if;
    logic        DIN_VALID;
    logic [23:0] DIN;
    logic        DIN_SOF;
    logic        DIN_EOL;
    logic [23:0] D00, D01, D02;
    logic [23:0] D10, D11, D12;
    logic [23:0] D20, D21, D22;
    logic        WIN_VALID;
    logic        WIN_SOF;
    logic        LINE_ERR;
    logic        BUSY;
    logic [1:0]  DBG_STATE;  // 0 idle, 1 fill, 2 run

    modport master (
        output DIN_VALID, DIN, DIN_SOF, DIN_EOL,
        input  D00, D01, D02, D10, D11, D12, D20, D21, D22,
        input  WIN_VALID, WIN_SOF, LINE_ERR, BUSY, DBG_STATE
    );

    modport slave (
        input  DIN_VALID, DIN, DIN_SOF, DIN_EOL,
        output D00, D01, D02, D10, D11, D12, D20, D21, D22,
        output WIN_VALID, WIN_SOF, LINE_ERR, BUSY, DBG_STATE
    );
endinterface

// File: rtl/window_ctrl.sv
`timescale 1ns/1ps
// 3x3 sliding-window generator over a raster pixel stream, built from two
// line buffers and a 3x3 shift window, with a two-stage output pipeline.
module window_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic         CLK,
    input  logic         RESET,
    window_ctrl_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    busy_q;
    logic [2:0][2:0][23:0]   win_q, win_d;   // [row][col]
    logic [2:0][2:0][23:0]   out_q;
    logic                    vld1_q, vld1_d, sof1_q, sof1_d, err1_q, err1_d;
    logic                    vld2_q, sof2_q, err2_q;

    logic [23:0]             line1_q [WIDTH];  // line y-1
    logic [23:0]             line2_q [WIDTH];  // line y-2

    logic                    take;
    logic [XW-1:0]           px;
    logic [YW-1:0]           py;
    logic                    at_last_x, eol_eff, line_err;
    logic [23:0]             rd1, rd2;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        take      = 1'b0;
        px        = x_q;
        py        = y_q;
        at_last_x = 1'b0;
        eol_eff   = 1'b0;
        line_err  = 1'b0;
        rd1       = '0;
        rd2       = '0;
        win_d     = win_q;
        vld1_d    = 1'b0;
        sof1_d    = 1'b0;
        err1_d    = 1'b0;

        // A SOF pixel always (re)starts a frame at (0,0); others only count mid-frame.
        if (bus.DIN_VALID) begin
            if (bus.DIN_SOF) begin
                take = 1'b1;
                px   = '0;
                py   = '0;
            end else if (state_q != IDLE) begin
                take = 1'b1;
            end
        end

        at_last_x = (px == XW'(WIDTH - 1));
        eol_eff   = bus.DIN_EOL || at_last_x;
        line_err  = take && (bus.DIN_EOL != at_last_x);
        rd1       = line1_q[px];
        rd2       = line2_q[px];

        if (take) begin
            if (bus.DIN_SOF) begin
                state_d = FILL;
            end
            if (eol_eff) begin
                x_d = '0;
                y_d = py + YW'(1);
                if (state_d == FILL && py == YW'(1)) begin
                    state_d = RUN;
                end else if (state_d == RUN && py == YW'(HEIGHT - 1)) begin
                    state_d = IDLE;
                    y_d     = '0;
                end
            end else begin
                x_d = px + XW'(1);
                y_d = py;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[0][0] = rd2;
            win_d[1][0] = rd1;
            win_d[2][0] = bus.DIN;

            vld1_d = (py >= YW'(2)) && (px >= XW'(2));
            sof1_d = (py == YW'(2)) && (px == XW'(2));
            err1_d = line_err;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            win_q   <= '0;
            out_q   <= '0;
            vld1_q  <= 1'b0;
            sof1_q  <= 1'b0;
            err1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            sof2_q  <= 1'b0;
            err2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= (state_d != IDLE);
            win_q   <= win_d;
            out_q   <= win_q;
            vld1_q  <= vld1_d;
            sof1_q  <= sof1_d;
            err1_q  <= err1_d;
            vld2_q  <= vld1_q;
            sof2_q  <= sof1_q;
            err2_q  <= err1_q;
        end
    end

    // Line buffers hold no reset; windows only use entries rewritten this frame.
    always_ff @(posedge CLK) begin
        if (take) begin
            line1_q[px] <= bus.DIN;
            line2_q[px] <= rd1;
        end
    end

    assign bus.D00       = out_q[0][0];
    assign bus.D01       = out_q[0][1];
    assign bus.D02       = out_q[0][2];
    assign bus.D10       = out_q[1][0];
    assign bus.D11       = out_q[1][1];
    assign bus.D12       = out_q[1][2];
    assign bus.D20       = out_q[2][0];
    assign bus.D21       = out_q[2][1];
    assign bus.D22       = out_q[2][2];
    assign bus.WIN_VALID = vld2_q;
    assign bus.WIN_SOF   = sof2_q;
    assign bus.LINE_ERR  = err2_q;
    assign bus.BUSY      = busy_q;
    assign bus.DBG_STATE = state_q;
endmodule

// File: tb/tb_window_ctrl.sv
`timescale 1ns/1ps
// Bench for window_ctrl on a 4x4 frame: directed frames plus a random stream
// against a per-column pixel-history model with a 2-cycle expected queue.
module tb_window_ctrl;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int REC_W = 220;  // {known, valid, sof, err, window[215:0]}

    logic CLK = 1'b0;
    logic RESET;

    window_ctrl_if bus();

    window_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [REC_W-1:0] exp_q[$];

    // Last three values written at each column, newest first.
    logic [23:0] hist [W][3];
    int          hcnt [W];
    bit          m_in_frame;
    int          m_x, m_y;

    int          c_valid, c_sof, c_err;
    logic [23:0] c_centre[$];
    logic [71:0] c_first_row2;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
    endtask

    function automatic int exp_state();
        if (!m_in_frame) return 0;
        return (m_y < 2) ? 1 : 2;
    endfunction

    function automatic logic [215:0] obs_window();
        return {bus.D22, bus.D21, bus.D20, bus.D12, bus.D11, bus.D10, bus.D02, bus.D01, bus.D00};
    endfunction

    task automatic model_step(input logic v, input logic [23:0] d, input logic s, input logic e);
        logic [REC_W-1:0] rec;
        int  px, py;
        bit  last, known;
        rec = '0;
        if (v && (s || m_in_frame)) begin
            px = s ? 0 : m_x;
            py = s ? 0 : m_y;
            hist[px][2] = hist[px][1];
            hist[px][1] = hist[px][0];
            hist[px][0] = d;
            if (hcnt[px] < 3) hcnt[px]++;
            last     = (px == W - 1);
            rec[216] = (e != last);
            if (px >= 2 && py >= 2) begin
                rec[218] = 1'b1;
                rec[217] = (px == 2 && py == 2);
                known    = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    if (hcnt[px-c] < 3) known = 1'b0;
                    for (int r = 0; r < 3; r++)
                        rec[(r*3+c)*24 +: 24] = hist[px-c][2-r];
                end
                rec[219] = known;
            end
            m_in_frame = 1'b1;
            if (e || last) begin
                m_x = 0;
                if (py == H - 1) begin
                    m_in_frame = 1'b0;
                    m_y        = 0;
                end else begin
                    m_y = py + 1;
                end
            end else begin
                m_x = px + 1;
                m_y = py;
            end
        end
        exp_q.push_back(rec);
    endtask

    task automatic check_outputs();
        logic [REC_W-1:0] rec;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 256'(exp_q.size()), 256'(1));
            return;
        end
        rec = exp_q.pop_front();
        check_val("win_valid", 256'(bus.WIN_VALID), 256'(rec[218]));
        check_val("win_sof",   256'(bus.WIN_SOF),   256'(rec[217]));
        check_val("line_err",  256'(bus.LINE_ERR),  256'(rec[216]));
        check_val("busy",      256'(bus.BUSY),      256'(m_in_frame));
        check_val("state",     256'(bus.DBG_STATE), 256'(exp_state()));
        if (rec[218] && rec[219])
            check_val("window", 256'(obs_window()), 256'(rec[215:0]));
        if (bus.WIN_VALID === 1'b1) begin
            c_valid++;
            if (c_valid == 1) c_first_row2 = {bus.D22, bus.D21, bus.D20};
            c_centre.push_back(bus.D11);
        end
        if (bus.WIN_SOF === 1'b1)  c_sof++;
        if (bus.LINE_ERR === 1'b1) c_err++;
    endtask

    task automatic drive_cycle(input logic v, input logic [23:0] d, input logic s, input logic e);
        bus.DIN_VALID = v;
        bus.DIN       = d;
        bus.DIN_SOF   = s;
        bus.DIN_EOL   = e;
        model_step(v, d, s, e);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic send_px(input logic [23:0] d, input logic s, input logic e);
        drive_cycle(1'b1, d, s, e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        RESET         = 1'b1;
        bus.DIN_VALID = 1'b0;
        #1;
        check_val("rst_win_valid", 256'(bus.WIN_VALID), 256'(0));
        check_val("rst_win_sof",   256'(bus.WIN_SOF),   256'(0));
        check_val("rst_line_err",  256'(bus.LINE_ERR),  256'(0));
        check_val("rst_busy",      256'(bus.BUSY),      256'(0));
        check_val("rst_state",     256'(bus.DBG_STATE), 256'(0));
        check_val("rst_window",    256'(obs_window()),  256'(0));
        @(posedge CLK);
        #1;
        RESET      = 1'b0;
        m_in_frame = 1'b0;
        m_x        = 0;
        m_y        = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic clear_collect();
        c_valid      = 0;
        c_sof        = 0;
        c_err        = 0;
        c_first_row2 = '0;
        c_centre.delete();
    endtask

    // Pixel value is 16*y+x; short_y ends that line at x=2, noeol_y drops EOL at x=W-1.
    task automatic send_frame(input bit toggle, input int short_y, input int noeol_y, input bit skip_first);
        int last_x;
        for (int y = 0; y < H; y++) begin
            last_x = (y == short_y) ? 2 : W - 1;
            for (int x = 0; x <= last_x; x++) begin
                if (skip_first && y == 0 && x == 0) continue;
                send_px(24'(16*y + x), 1'(x == 0 && y == 0), 1'(x == last_x && y != noeol_y));
                if (toggle) idle(1);
            end
        end
    endtask

    task automatic send_partial(input int nlines, input int nx);
        for (int y = 0; y < nlines; y++)
            for (int x = 0; x < W; x++)
                send_px(24'(16*y + x), 1'(x == 0 && y == 0), 1'(x == W - 1));
        for (int x = 0; x < nx; x++)
            send_px(24'(16*nlines + x), 1'(nlines == 0 && x == 0), 1'b0);
    endtask

    task automatic check_frame_windows(input string tag);
        logic [23:0] centres [4];
        centres[0] = 24'h11;
        centres[1] = 24'h12;
        centres[2] = 24'h21;
        centres[3] = 24'h22;
        check_val({tag, "_count"}, 256'(c_valid), 256'(4));
        check_val({tag, "_sof"},   256'(c_sof),   256'(1));
        for (int i = 0; i < 4; i++)
            if (i < c_centre.size())
                check_val($sformatf("%s_centre%0d", tag, i), 256'(c_centre[i]), 256'(centres[i]));
    endtask

    task automatic run_random(input int n);
        logic v, s, e;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            v = ($urandom_range(0, 3) != 0);
            s = m_in_frame ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) != 0);
            e = 1'(m_x == W - 1) ^ 1'($urandom_range(0, 19) == 0);
            drive_cycle(v, 24'($urandom), s, e);
        end
    endtask

    initial begin
        RESET         = 1'b0;
        bus.DIN_VALID = 1'b0;
        bus.DIN       = '0;
        bus.DIN_SOF   = 1'b0;
        bus.DIN_EOL   = 1'b0;
        m_in_frame    = 1'b0;
        m_x           = 0;
        m_y           = 0;
        for (int i = 0; i < W; i++) hcnt[i] = 0;
        clear_collect();
        #2;
        do_reset();

        // Pixels before any SOF are dropped.
        clear_collect();
        for (int i = 0; i < 6; i++) send_px(24'(i + 'h100), 1'b0, 1'(i == 3));
        idle(3);
        check_val("presof_valid", 256'(c_valid), 256'(0));
        check_val("presof_busy",  256'(bus.BUSY), 256'(0));

        // Continuous frame.
        clear_collect();
        send_frame(1'b0, -1, -1, 1'b0);
        idle(3);
        check_frame_windows("cont");
        check_val("cont_first_row2", 256'(c_first_row2), 256'({24'h20, 24'h21, 24'h22}));
        check_val("cont_end_state",  256'(bus.DBG_STATE), 256'(0));

        // Valid toggling every cycle.
        clear_collect();
        send_frame(1'b1, -1, -1, 1'b0);
        idle(3);
        check_frame_windows("toggle");

        // Short line 1.
        clear_collect();
        send_frame(1'b0, 1, -1, 1'b0);
        idle(3);
        check_val("short_err",   256'(c_err), 256'(1));
        check_val("short_count", 256'(c_valid), 256'(4));
        check_val("short_state", 256'(bus.DBG_STATE), 256'(0));
        check_val("short_busy",  256'(bus.BUSY), 256'(0));

        // Line 2 reaches the last column without EOL.
        clear_collect();
        send_frame(1'b0, -1, 2, 1'b0);
        idle(3);
        check_val("noeol_err", 256'(c_err), 256'(1));
        check_frame_windows("noeol");

        // SOF re-issued where (2,3) would be.
        send_partial(3, 2);
        clear_collect();
        send_px(24'h00, 1'b1, 1'b0);
        check_val("restart_state", 256'(bus.DBG_STATE), 256'(1));
        check_val("restart_busy",  256'(bus.BUSY), 256'(1));
        send_frame(1'b0, -1, -1, 1'b1);
        idle(3);
        check_frame_windows("restart");

        // Reset during line 2, then pixels without SOF.
        send_partial(2, 3);
        do_reset();
        clear_collect();
        send_px(24'h23, 1'b0, 1'b1);
        for (int x = 0; x < W; x++) send_px(24'(16*3 + x), 1'b0, 1'(x == W - 1));
        idle(3);
        check_val("midrst_valid", 256'(c_valid), 256'(0));
        check_val("midrst_busy",  256'(bus.BUSY), 256'(0));

        run_random(1500);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 Parameter: WIDTH, 640, active pixels per line (>=3).
REQ-002 Parameter: HEIGHT, 480, active lines per frame (>=3).
REQ-003 Port: CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 Port: RESET  in  1  asynchronous, active-high reset.
REQ-005 Port: DIN_VALID  in  1  pixel qualifier; one pixel accepted per cycle when high.
REQ-006 Port: DIN  in  24  RGB pixel [23:16]R [15:8]G [7:0]B.
REQ-007 Port: DIN_SOF  in  1  first pixel of frame; sampled only with DIN_VALID.
REQ-008 Port: DIN_EOL  in  1  last pixel of line; sampled only with DIN_VALID.
REQ-009 Port: D02,D01,D00 / D12,D11,D10 / D22,D21,D20  out  24 each  3x3 window; row 0 = oldest line, row 2 = current line, column 0 = newest pixel, D11 = centre.
REQ-010 Port: WIN_VALID  out  1  window outputs valid this cycle.
REQ-011 Port: WIN_SOF  out  1  first window of frame, coincident with WIN_VALID.
REQ-012 Port: LINE_ERR  out  1  one-cycle pulse on line-length violation.
REQ-013 Port: BUSY  out  1  high when FSM is in FILL or RUN.

Function
REQ-014 FSM states IDLE, FILL, RUN; reset state IDLE.
REQ-015 IDLE: accepted pixels without DIN_SOF are discarded; accepted DIN_SOF -> FILL with that pixel stored at x=0,y=0.
REQ-016 Counters x (0..WIDTH-1), y (0..HEIGHT-1) advance only on accepted pixels; x clears to 0 and y increments on accepted DIN_EOL.
REQ-017 FILL -> RUN on accepted DIN_EOL when y=1; RUN -> IDLE on accepted DIN_EOL when y=HEIGHT-1.
REQ-018 Accepted DIN_SOF in FILL or RUN restarts the frame: x=0,y=0, state FILL, pixel stored at (0,0); no WIN_VALID generated for that pixel.
REQ-019 Two line buffers of depth WIDTH, addressed by x: each accepted pixel reads lines y-1 and y-2 at x and writes DIN into line y-1 buffer, line y-1 content into line y-2 buffer (read-before-write).
REQ-020 Window registers shift one column per accepted pixel: new column = {line y-2, line y-1, DIN}; idle cycles hold window and all counters.
REQ-021 WIN_VALID asserts exactly 2 cycles after acceptance of pixel (x,y) when y>=2 and x>=2; window centre D11 = pixel (x-1,y-1).
REQ-022 Border centres (row 0, row HEIGHT-1, column 0, column WIDTH-1) produce no window; exactly (WIDTH-2)*(HEIGHT-2) WIN_VALID pulses per complete frame.
REQ-023 WIN_SOF asserts with the WIN_VALID of pixel (2,2) only.
REQ-024 DIN_EOL with x != WIDTH-1: LINE_ERR pulses 2 cycles later, line ends normally (x=0, y+1).
REQ-025 Pixel arriving at x=WIDTH-1 without DIN_EOL: treated as EOL, LINE_ERR pulses 2 cycles later.
REQ-026 Pipeline side-band (WIN_VALID, WIN_SOF, LINE_ERR) delayed as a matched 2-stage chain; no back-pressure input exists.
REQ-027 BUSY is a registered decode of the FSM state.

Reset
REQ-028 RESET asserted: state IDLE, x=y=0, all D* outputs 0, WIN_VALID/WIN_SOF/LINE_ERR/BUSY 0, pipeline stages cleared, immediately and asynchronously.
REQ-029 Line buffer contents are not reset; no output depends on them before being rewritten in the current frame.
REQ-030 RESET mid-frame drops the frame; following pixels are ignored until the next DIN_SOF.

Verification (WIDTH=4, HEIGHT=4, DIN=16*y+x)
REQ-031 Full frame, DIN_VALID continuous -> 4 WIN_VALID pulses, centres D11 = 0x11,0x12,0x21,0x22; first window D22..D20 = 0x20..0x22 order D20=0x22, WIN_SOF with first only.
REQ-032 Same frame with DIN_VALID toggled 1/0 each cycle -> identical window values, each WIN_VALID 2 cycles after its pixel.
REQ-033 DIN_EOL at x=2 on line 1 -> LINE_ERR single pulse, y advances, no hang, frame ends in IDLE.
REQ-034 DIN_SOF re-issued at (2,3) -> state FILL, counters cleared, next complete frame yields 4 correct windows.
REQ-035 RESET asserted during line 2 -> all outputs 0 same cycle, BUSY 0; pixels without SOF afterwards produce no WIN_VALID.
REQ-036 Pixels before first DIN_SOF -> discarded, BUSY 0, no WIN_VALID.
